// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator front-end and controller.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   DEF_DEBOUNCE_CYCLES - default stable cycles to accept a button level change
//   DEF_CHIME_CYCLES    - default arrival chime length in cycles
//   floor_bits()        - floor index width for a given floor count
package elevator_pkg;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_CHIME_CYCLES    = 8;

   // $clog2 of 1 is 0, which is not a usable vector width, so clamp at 1.
   function automatic int floor_bits(input int n_floors);
      return (n_floors < 2) ? 1 : $clog2(n_floors);
   endfunction

endpackage

// File: rtl/elevator_call_panel_if.sv
// Bundle of all signals between the button front-end, the buttons/lamps and the controller.
// Latency: n/a (wiring only).
// Backpressure: none; requests are fire-and-forget pulses latched by the controller.
//
// Modports:
//   slave  - the call panel: takes raw buttons and controller state, drives pulses/lamps/arrival
//   master - the environment (controller + physical panel) on the other side
interface elevator_call_panel_if
   import elevator_pkg::*;
#(
   parameter int N_FLOORS = 4,
   parameter int F_BITS   = floor_bits(N_FLOORS)
) ();

   // raw, asynchronous, active-high push-buttons
   logic [N_FLOORS-1:0] raw_up;
   logic [N_FLOORS-1:0] raw_down;
   logic [N_FLOORS-1:0] raw_floor;

   // controller state
   logic [N_FLOORS-1:0] u_buttons;
   logic [N_FLOORS-1:0] d_buttons;
   logic [N_FLOORS-1:0] f_buttons;
   logic [F_BITS-1:0]   cur_floor;
   logic                doors_open;

   // panel outputs
   logic [N_FLOORS-1:0] ext_up;
   logic [N_FLOORS-1:0] ext_down;
   logic [N_FLOORS-1:0] ext_floor;
   logic [N_FLOORS-1:0] lamp_up;
   logic [N_FLOORS-1:0] lamp_down;
   logic [N_FLOORS-1:0] lamp_floor;
   logic                arrive_pulse;
   logic [F_BITS-1:0]   arrive_floor;
   logic                chime;

   modport slave (
      input  raw_up, raw_down, raw_floor,
      input  u_buttons, d_buttons, f_buttons, cur_floor, doors_open,
      output ext_up, ext_down, ext_floor,
      output lamp_up, lamp_down, lamp_floor,
      output arrive_pulse, arrive_floor, chime
   );

   modport master (
      output raw_up, raw_down, raw_floor,
      output u_buttons, d_buttons, f_buttons, cur_floor, doors_open,
      input  ext_up, ext_down, ext_floor,
      input  lamp_up, lamp_down, lamp_floor,
      input  arrive_pulse, arrive_floor, chime
   );

endinterface

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, debounce counter, single-cycle press pulse.
// Latency: raw first sampled at edge 1 -> db at edge DEBOUNCE_CYCLES+2 -> pulse after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; the pulse is dropped when the controller already holds the request (i_held).
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_raw      - asynchronous raw button level
//   i_held     - controller already latched this request; suppresses the pulse
//   o_pulse    - registered one-cycle pulse on an accepted press
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   input  logic i_held,
   output logic o_pulse
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   // The flip happens on the edge that would take the count to DEBOUNCE_CYCLES,
   // so the count itself only ever needs to reach DEBOUNCE_CYCLES-1.
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_db;
   logic          r_db_q;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;
   logic          w_rise;

   assign w_rise  = r_db & ~r_db_q;
   assign o_pulse = r_pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_db    <= 1'b0;
         r_db_q  <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;

         // Any cycle that agrees with the accepted level restarts the count,
         // so only an uninterrupted run of disagreeing samples flips db.
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_db  <= ~r_db;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         r_db_q  <= r_db;
         r_pulse <= w_rise & ~i_held;
      end
   end

endmodule

// File: rtl/elevator_call_panel.sv
// Button front-end for the elevator controller: debounced request pulses, lamps, arrival event and chime.
// Latency: press -> ext_* pulse after edge DEBOUNCE_CYCLES+3; doors_open rise -> arrive_pulse/chime one edge later.
// Backpressure: none; pulses are suppressed while the controller already holds the same request.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of elevator_call_panel_if:
//                raw_* buttons in, *_buttons/cur_floor/doors_open from the controller,
//                ext_* pulses, lamp_* drives, arrive_pulse/arrive_floor/chime out
module elevator_call_panel
   import elevator_pkg::*;
#(
   parameter int N_FLOORS        = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CHIME_CYCLES    = DEF_CHIME_CYCLES,
   parameter int F_BITS          = floor_bits(N_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   elevator_call_panel_if.slave  bus
);

   // No UP call from the top floor and no DOWN call from the bottom floor.
   localparam logic [N_FLOORS-1:0] UP_MASK   = {1'b0, {(N_FLOORS-1){1'b1}}};
   localparam logic [N_FLOORS-1:0] DOWN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

   localparam int              CHW        = $clog2(CHIME_CYCLES + 1);
   localparam logic [CHW-1:0]  CHIME_LOAD = CHW'(CHIME_CYCLES);

   logic [N_FLOORS-1:0] w_ext_up;
   logic [N_FLOORS-1:0] w_ext_down;
   logic [N_FLOORS-1:0] w_ext_floor;
   logic                w_unused_raw;

   // ------------------------------------------------------------------
   // Per-button debouncers. Impossible calls get no debouncer at all.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < N_FLOORS; i++) begin : g_btn
      if (i < N_FLOORS - 1) begin : g_up
         button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (bus.raw_up[i]),
            .i_held  (bus.u_buttons[i]),
            .o_pulse (w_ext_up[i])
         );
      end else begin : g_up_none
         assign w_ext_up[i] = 1'b0;
      end

      if (i > 0) begin : g_down
         button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (bus.raw_down[i]),
            .i_held  (bus.d_buttons[i]),
            .o_pulse (w_ext_down[i])
         );
      end else begin : g_down_none
         assign w_ext_down[i] = 1'b0;
      end

      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_floor (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_raw   (bus.raw_floor[i]),
         .i_held  (bus.f_buttons[i]),
         .o_pulse (w_ext_floor[i])
      );
   end

   // The raw inputs of the masked calls are deliberately ignored.
   assign w_unused_raw = bus.raw_up[N_FLOORS-1] ^ bus.raw_down[0];

   assign bus.ext_up    = w_ext_up;
   assign bus.ext_down  = w_ext_down;
   assign bus.ext_floor = w_ext_floor;

   // Lamps light in the pulse cycle itself, before the controller has
   // latched the request, and then track the controller's latched state.
   assign bus.lamp_up    = (bus.u_buttons | w_ext_up)    & UP_MASK;
   assign bus.lamp_down  = (bus.d_buttons | w_ext_down)  & DOWN_MASK;
   assign bus.lamp_floor =  bus.f_buttons | w_ext_floor;

   // ------------------------------------------------------------------
   // Arrival detection and chime timer
   // ------------------------------------------------------------------
   logic              r_doors_q;
   logic              r_arrive_pulse;
   logic [F_BITS-1:0] r_arrive_floor;
   logic [CHW-1:0]    r_chime_cnt;
   logic              w_arrive;

   // doors_q resets to 0, so doors already open on the first edge after
   // reset count as a fresh arrival.
   assign w_arrive = bus.doors_open & ~r_doors_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_doors_q      <= 1'b0;
         r_arrive_pulse <= 1'b0;
         r_arrive_floor <= '0;
         r_chime_cnt    <= '0;
      end else begin
         r_doors_q      <= bus.doors_open;
         r_arrive_pulse <= w_arrive;
         if (w_arrive) begin
            r_arrive_floor <= bus.cur_floor;
            // A new arrival restarts the chime from full length.
            r_chime_cnt    <= CHIME_LOAD;
         end else if (r_chime_cnt != '0) begin
            r_chime_cnt    <= r_chime_cnt - 1'b1;
         end
      end
   end

   assign bus.arrive_pulse = r_arrive_pulse;
   assign bus.arrive_floor = r_arrive_floor;
   assign bus.chime        = (r_chime_cnt != '0);

endmodule

// File: tb/tb_elevator_call_panel.sv
module tb_elevator_call_panel;
   import elevator_pkg::*;

   localparam int N    = 4;
   localparam int D    = 16;
   localparam int C    = 8;
   localparam int PE   = D + 3;   // edge after which the press pulse is visible
   localparam int WIN  = 72;      // per-vector observation window (press + full release)
   localparam int NVEC = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   elevator_call_panel_if #(.N_FLOORS(N)) bus ();

   elevator_call_panel #(
      .N_FLOORS        (N),
      .DEBOUNCE_CYCLES (D),
      .CHIME_CYCLES    (C)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // sel: 0 = up, 1 = down, 2 = floor
   typedef struct {
      int         sel;
      int         idx;
      int         hold;
      logic [3:0] btn;       // controller latched state for this group
      int         exp_edge;  // 0 = no pulse expected
      logic       exp_lamp;  // lamp of the pressed bit after edge PE
   } vec_t;

   vec_t vecs[NVEC];

   task automatic set_raw(input int sel, input int idx, input logic v);
      case (sel)
         0:       bus.raw_up[idx]    = v;
         1:       bus.raw_down[idx]  = v;
         default: bus.raw_floor[idx] = v;
      endcase
   endtask

   task automatic set_btn(input int sel, input logic [3:0] v);
      case (sel)
         0:       bus.u_buttons = v;
         1:       bus.d_buttons = v;
         default: bus.f_buttons = v;
      endcase
   endtask

   function automatic logic [3:0] get_ext(input int sel);
      case (sel)
         0:       return bus.ext_up;
         1:       return bus.ext_down;
         default: return bus.ext_floor;
      endcase
   endfunction

   function automatic logic [3:0] get_lamp(input int sel);
      case (sel)
         0:       return bus.lamp_up;
         1:       return bus.lamp_down;
         default: return bus.lamp_floor;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, cnt, stray;
      logic lamp;
      logic [3:0] mask, ext_hit;
      logic ap[1:24];
      logic ch[1:24];
      logic [1:0] af[1:24];
      int n_ap, n_ch;

      vecs[0] = '{sel: 2, idx: 3, hold: 40, btn: 4'b0000, exp_edge: PE, exp_lamp: 1'b1}; // clean press
      vecs[1] = '{sel: 0, idx: 1, hold: 10, btn: 4'b0000, exp_edge: 0,  exp_lamp: 1'b0}; // glitch
      vecs[2] = '{sel: 0, idx: 1, hold: 40, btn: 4'b0000, exp_edge: PE, exp_lamp: 1'b1}; // counter was cleared
      vecs[3] = '{sel: 1, idx: 2, hold: 40, btn: 4'b0100, exp_edge: 0,  exp_lamp: 1'b1}; // suppressed
      vecs[4] = '{sel: 0, idx: 3, hold: 40, btn: 4'b1000, exp_edge: 0,  exp_lamp: 1'b0}; // masked up[top]
      vecs[5] = '{sel: 1, idx: 0, hold: 40, btn: 4'b0001, exp_edge: 0,  exp_lamp: 1'b0}; // masked down[0]
      vecs[6] = '{sel: 2, idx: 0, hold: 15, btn: 4'b0000, exp_edge: 0,  exp_lamp: 1'b0}; // one short of D
      vecs[7] = '{sel: 2, idx: 0, hold: 16, btn: 4'b0000, exp_edge: PE, exp_lamp: 1'b1}; // exactly D
      vecs[8] = '{sel: 1, idx: 3, hold: 16, btn: 4'b0000, exp_edge: PE, exp_lamp: 1'b1};
      vecs[9] = '{sel: 0, idx: 0, hold: 40, btn: 4'b0010, exp_edge: PE, exp_lamp: 1'b1}; // other bit held

      bus.raw_up     = '0;
      bus.raw_down   = '0;
      bus.raw_floor  = '0;
      bus.u_buttons  = 4'b1011;
      bus.d_buttons  = 4'b0011;
      bus.f_buttons  = 4'b0100;
      bus.cur_floor  = 2'd2;
      bus.doors_open = 1'b1;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst_ext_up",       32'(bus.ext_up),       32'h0);
      check("rst_ext_down",     32'(bus.ext_down),     32'h0);
      check("rst_ext_floor",    32'(bus.ext_floor),    32'h0);
      check("rst_arrive_pulse", 32'(bus.arrive_pulse), 32'h0);
      check("rst_arrive_floor", 32'(bus.arrive_floor), 32'h0);
      check("rst_chime",        32'(bus.chime),        32'h0);
      check("rst_lamp_up",      32'(bus.lamp_up),      32'h3);
      check("rst_lamp_down",    32'(bus.lamp_down),    32'h2);
      check("rst_lamp_floor",   32'(bus.lamp_floor),   32'h4);
      bus.u_buttons = '0;
      bus.d_buttons = '0;
      bus.f_buttons = '0;

      // -------- doors open through reset: arrival on first edge --------
      @(negedge clk);
      rst_n = 1'b1;
      n_ch = 0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         ap[e] = bus.arrive_pulse;
         ch[e] = bus.chime;
         af[e] = bus.arrive_floor;
         if (bus.chime) n_ch++;
      end
      check("boot_arrive_pulse_e1", 32'(ap[1]), 32'h1);
      check("boot_arrive_pulse_e2", 32'(ap[2]), 32'h0);
      check("boot_arrive_floor",    32'(af[1]), 32'h2);
      check("boot_chime_e8",        32'(ch[8]), 32'h1);
      check("boot_chime_e9",        32'(ch[9]), 32'h0);
      check("boot_chime_len",       32'(n_ch),  32'(C));
      bus.doors_open = 1'b0;
      repeat (3) @(posedge clk);

      // ---------------- table-driven button vectors ----------------
      for (int i = 0; i < NVEC; i++) begin
         @(posedge clk);
         #1;
         set_btn(vecs[i].sel, vecs[i].btn);
         set_raw(vecs[i].sel, vecs[i].idx, 1'b1);
         mask  = 4'b0001 << vecs[i].idx;
         first = 0;
         cnt   = 0;
         stray = 0;
         lamp  = 1'b0;
         for (int e = 1; e <= WIN; e++) begin
            @(posedge clk);
            #1;
            if (e == vecs[i].hold) set_raw(vecs[i].sel, vecs[i].idx, 1'b0);
            ext_hit = get_ext(vecs[i].sel);
            if ((ext_hit & mask) != 4'b0000) begin
               if (first == 0) first = e;
               cnt++;
            end
            for (int s = 0; s < 3; s++) begin
               if (s == vecs[i].sel) begin
                  if ((get_ext(s) & ~mask) != 4'b0000) stray++;
               end else if (get_ext(s) != 4'b0000) begin
                  stray++;
               end
            end
            if (e == PE) lamp = get_lamp(vecs[i].sel)[vecs[i].idx];
         end
         check($sformatf("vec%0d_pulse_edge", i),  32'(first), 32'(vecs[i].exp_edge));
         check($sformatf("vec%0d_pulse_count", i), 32'(cnt),   (vecs[i].exp_edge != 0) ? 32'h1 : 32'h0);
         check($sformatf("vec%0d_stray", i),       32'(stray), 32'h0);
         check($sformatf("vec%0d_lamp", i),        32'(lamp),  32'(vecs[i].exp_lamp));
         set_btn(vecs[i].sel, 4'b0000);
      end

      // ---------------- simultaneous presses ----------------
      @(posedge clk);
      #1;
      bus.raw_up[0]    = 1'b1;
      bus.raw_floor[2] = 1'b1;
      cnt = 0;
      for (int e = 1; e <= WIN; e++) begin
         @(posedge clk);
         #1;
         if (e == 30) begin
            bus.raw_up[0]    = 1'b0;
            bus.raw_floor[2] = 1'b0;
         end
         if (e == PE) begin
            check("simul_ext_up",    32'(bus.ext_up),    32'h1);
            check("simul_ext_floor", 32'(bus.ext_floor), 32'h4);
         end
         if (bus.ext_up != 4'b0000 || bus.ext_floor != 4'b0000) cnt++;
      end
      check("simul_pulse_cycles", 32'(cnt), 32'h1);

      // ---------------- arrival with chime reload ----------------
      bus.cur_floor = 2'd3;
      @(posedge clk);
      #1;
      bus.doors_open = 1'b1;
      n_ap = 0;
      n_ch = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         ap[e] = bus.arrive_pulse;
         ch[e] = bus.chime;
         af[e] = bus.arrive_floor;
         if (bus.arrive_pulse) n_ap++;
         if (bus.chime) n_ch++;
         if (e == 2) bus.doors_open = 1'b0;
         if (e == 4) begin
            bus.doors_open = 1'b1;
            bus.cur_floor  = 2'd1;
         end
      end
      check("arr_pulse_e1",   32'(ap[1]), 32'h1);
      check("arr_floor_e1",   32'(af[1]), 32'h3);
      check("arr_chime_e1",   32'(ch[1]), 32'h1);
      check("arr_floor_hold", 32'(af[4]), 32'h3);
      check("arr_pulse_e5",   32'(ap[5]), 32'h1);
      check("arr_pulses",     32'(n_ap),  32'h2);
      check("arr_floor_e5",   32'(af[5]), 32'h1);
      check("arr_chime_e12",  32'(ch[12]), 32'h1);
      check("arr_chime_e13",  32'(ch[13]), 32'h0);
      check("arr_chime_len",  32'(n_ch),  32'd12);
      check("arr_floor_e20",  32'(af[20]), 32'h1);
      bus.doors_open = 1'b0;

      // ---------------- reset in the middle of a press ----------------
      @(posedge clk);
      #1;
      bus.raw_floor[1] = 1'b1;
      cnt = 0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         #1;
         if (bus.ext_floor != 4'b0000) cnt++;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_no_pulse_before", 32'(cnt),              32'h0);
      check("midrst_ext_floor",       32'(bus.ext_floor),    32'h0);
      check("midrst_arrive_floor",    32'(bus.arrive_floor), 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      first = 0;
      cnt   = 0;
      for (int e = 1; e <= WIN; e++) begin
         @(posedge clk);
         #1;
         if (e == 30) bus.raw_floor[1] = 1'b0;
         if (bus.ext_floor[1]) begin
            if (first == 0) first = e;
            cnt++;
         end
      end
      check("midrst_reaccept_edge",  32'(first), 32'(PE));
      check("midrst_reaccept_count", 32'(cnt),   32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_call_panel.md
# elevator_call_panel

Front-end between the physical hall/car push-buttons and `elevator_top`. Synchronises and debounces every raw button, and converts each accepted press into the single-cycle `ext_up`/`ext_down`/`ext_floor` request pulse the controller latches. It also drives the button lamps from the controller's latched `u_buttons`/`d_buttons`/`f_buttons`, and derives an arrival event plus a timed chime from `doors_open`/`cur_floor`.

## Interface
- `N_FLOORS`, 4: number of floors; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed to accept a level change; must be ≥ 1.
- `CHIME_CYCLES`, 8: length of the `chime` pulse in cycles; must be ≥ 1.
- `F_BITS`, `$clog2(N_FLOORS)`: floor index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `raw_up`  in  N_FLOORS  hall UP buttons, asynchronous, active-high.
- `raw_down`  in  N_FLOORS  hall DOWN buttons, asynchronous, active-high.
- `raw_floor`  in  N_FLOORS  car-panel floor buttons, asynchronous, active-high.
- `u_buttons`, `d_buttons`, `f_buttons`  in  N_FLOORS each  latched requests from the controller.
- `cur_floor`  in  F_BITS  current floor from the controller.
- `doors_open`  in  1  door state from the controller.
- `ext_up`, `ext_down`, `ext_floor`  out  N_FLOORS each  one-cycle request pulses to the controller.
- `lamp_up`, `lamp_down`, `lamp_floor`  out  N_FLOORS each  button lamp drives.
- `arrive_pulse`  out  1  one-cycle arrival event.
- `arrive_floor`  out  F_BITS  floor of the last arrival, held until the next arrival.
- `chime`  out  1  arrival chime enable.

## Operation
- Every raw bit passes through a 2-flop synchroniser. The synchroniser resets to 0.
- Debounce, per bit:
  - State: debounced level `db` (reset 0) and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If sync ≠ `db`, the counter increments. If sync = `db`, the counter clears to 0.
  - When the counter reaches `DEBOUNCE_CYCLES`, `db` flips and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` changes nothing.
- Request pulse: on a 0→1 change of `db`, the matching `ext_*` bit is registered high for exactly one cycle. The pulse is suppressed if the same bit of `u_/d_/f_buttons` is already 1. Release (1→0) produces no pulse.
- Impossible calls are masked: `ext_up[N_FLOORS-1]` and `ext_down[0]` are tied 0. Their debouncers are not instantiated.
- Lamps: `lamp_x = x_buttons | ext_x`, so the lamp lights in the pulse cycle and stays lit while the controller holds the request. The same masks apply.
- Arrival:
  - `doors_open` is registered into `doors_q` (reset 0).
  - On `doors_open & ~doors_q`: `arrive_pulse` = 1 for one cycle, `arrive_floor` ← `cur_floor`, and the chime counter loads `CHIME_CYCLES`.
  - `chime` = (counter ≠ 0). The counter decrements to 0.
  - A new arrival while the chime is running reloads the counter.
- Bits are independent. Any number of `ext_*` pulses may be high in the same cycle.

## Timing
- Reset values: all outputs 0 except `lamp_*`, which follow `*_buttons` combinationally. All counters and `db` are 0.
- Press latency: with the raw bit first sampled high at edge 1 and held, `db` sets at edge `DEBOUNCE_CYCLES+2`. The `ext_*` pulse is high for the cycle after edge `DEBOUNCE_CYCLES+3`.
- Release latency is the same. A new press is accepted only after `db` has returned to 0.
- A button held through reset is treated as a fresh press: pulse after the full latency following `rst_n` rising.
- `doors_open` high on the first post-reset edge counts as an arrival.
- `arrive_pulse` appears one edge after the `doors_open` rise. `chime` is high for exactly `CHIME_CYCLES` cycles, starting in the same cycle.
- Asynchronous reset mid-operation: all state clears immediately; in-flight presses are lost.

## Structure
- Shared package `elevator_pkg`:
  - floor-index width function;
  - default `DEBOUNCE_CYCLES` and `CHIME_CYCLES`.
  - `elevator_top` imports the same width function.
- Sub-module `button_debounce`: synchroniser, debounce counter and rising-edge pulse for one bit. 3·N_FLOORS − 2 instances.
- Arrival/chime logic lives in the top of this block.

## Test plan
- Clean press: `raw_floor[3]` held 40 cycles, `DEBOUNCE_CYCLES`=16, `f_buttons`=0 → `ext_floor`=4'b1000 for exactly one cycle, after edge 19. `lamp_floor[3]` is high in the same cycle.
- Glitch rejection: `raw_up[1]` high for 10 cycles, then low → no `ext_up` pulse; counter returns to 0.
- Suppression and masking:
  - `raw_down[2]` debounced while `d_buttons[2]`=1 → no pulse; `lamp_down[2]` stays 1.
  - `raw_up[3]` held → `ext_up` stays 0.
- Simultaneous presses: `raw_up[0]` and `raw_floor[2]` rise on the same edge → `ext_up[0]` and `ext_floor[2]` pulse in the same cycle.
- Arrival:
  - `cur_floor`=3 with `doors_open` 0→1 → `arrive_pulse` for 1 cycle, `arrive_floor`=3, `chime` high 8 cycles.
  - A second rise after 4 cycles → `chime` extends to 8 cycles from the reload.
- Reset mid-debounce: `rst_n` low at cycle 10 of a press → no pulse. The press is re-accepted after the full latency from reset release.
